// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write controller.
package rf_pkg;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // One register-file write port beat.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
  } wr_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone valid always wins, a tie goes to prio.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);
  assign grant[0] = valid[0] & (~valid[1] | ~prio);
  assign grant[1] = valid[1] & (~valid[0] |  prio);
endmodule

// File: rtl/rf_wr_ctrl.sv
// Write-port controller for an 8x4 register file: arbitrates two writers
// round-robin and runs an eight-cycle clear sweep that pre-empts them.
module rf_wr_ctrl
  import rf_pkg::*;
#(
  parameter logic [DATA_W-1:0] CLR_VAL = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_val,
  output logic              rf_wr_en
);
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              prio;
  wr_t               wr;
  logic [1:0]        grant;
  logic              open;
  logic              hs;

  // Writers may only be granted in IDLE, out of reset, with no clear pending.
  assign open = (state == IDLE) & ~clr_req & ~rst;

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .prio  (prio),
    .grant (grant)
  );

  assign req0_ready = open & grant[0];
  assign req1_ready = open & grant[1];
  assign hs         = req0_ready | req1_ready;

  assign rf_wr_en   = wr.en;
  assign rf_wr_addr = wr.addr;
  assign rf_wr_val  = wr.val;

  // Sweep sequencing, accepted-write capture and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      prio     <= 1'b0;
      wr       <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clr_req) begin
            // Address 0 is written in the very first sweep cycle.
            state    <= CLEAR;
            cnt      <= '0;
            wr       <= '{en: 1'b1, addr: '0, val: CLR_VAL};
            clr_busy <= 1'b1;
          end else if (hs) begin
            wr.en   <= 1'b1;
            wr.addr <= req0_ready ? req0_addr : req1_addr;
            wr.val  <= req0_ready ? req0_data : req1_data;
            // Pointer moves to whoever lost (or was not asking).
            prio    <= req0_ready;
          end else begin
            wr.en <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt == ADDR_W'(NUM_REGS - 1)) begin
            state    <= IDLE;
            wr.en    <= 1'b0;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt     <= cnt + 1'b1;
            wr.addr <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_wr_ctrl.sv
// Bench for rf_wr_ctrl: a queue-based behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rf_wr_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 0, req1_valid = 0, clr_req = 0;
  logic [2:0] req0_addr = 0, req1_addr = 0;
  logic [3:0] req0_data = 0, req1_data = 0;
  logic       req0_ready, req1_ready, clr_busy, clr_done, rf_wr_en;
  logic [2:0] rf_wr_addr;
  logic [3:0] rf_wr_val;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_wr_ctrl #(.CLR_VAL(4'b0000)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_wr_addr(rf_wr_addr), .rf_wr_val(rf_wr_val), .rf_wr_en(rf_wr_en)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit       en;
    bit [2:0] a;
    bit [3:0] v;
    bit       busy;
    bit       done;
  } rec_t;

  rec_t     q[$];
  bit       m_en = 0, m_busy = 0, m_done = 0, m_prio = 0;
  bit [2:0] m_a = 0;
  bit [3:0] m_v = 0;

  function automatic bit m_rdy0();
    return !rst && !clr_req && !m_busy && req0_valid && (!req1_valid || !m_prio);
  endfunction
  function automatic bit m_rdy1();
    return !rst && !clr_req && !m_busy && req1_valid && (!req0_valid || m_prio);
  endfunction

  always @(posedge clk) begin
    bit g0, g1;
    rec_t r;
    g0 = m_rdy0();
    g1 = m_rdy1();
    if (rst) begin
      q.delete();
      m_en = 0; m_a = 0; m_v = 0; m_busy = 0; m_done = 0; m_prio = 0;
    end else begin
      if (q.size() == 0 && clr_req) begin
        for (int i = 0; i < 8; i++) q.push_back('{1'b1, 3'(i), 4'h0, 1'b1, 1'b0});
        q.push_back('{1'b0, 3'd7, 4'h0, 1'b0, 1'b1});
      end
      if (q.size() != 0) begin
        r = q.pop_front();
        m_en = r.en; m_a = r.a; m_v = r.v; m_busy = r.busy; m_done = r.done;
      end else begin
        m_busy = 0; m_done = 0; m_en = 0;
        if (g0) begin
          m_en = 1; m_a = req0_addr; m_v = req0_data; m_prio = 1;
        end else if (g1) begin
          m_en = 1; m_a = req1_addr; m_v = req1_data; m_prio = 0;
        end
      end
    end
  end

  // Compare process: mid-cycle, away from the active edge.
  always @(negedge clk) begin
    chk("req0_ready", int'(req0_ready), int'(m_rdy0()));
    chk("req1_ready", int'(req1_ready), int'(m_rdy1()));
    chk("rf_wr_en",   int'(rf_wr_en),   int'(m_en));
    chk("clr_busy",   int'(clr_busy),   int'(m_busy));
    chk("clr_done",   int'(clr_done),   int'(m_done));
    if (m_en) begin
      chk("rf_wr_addr", int'(rf_wr_addr), int'(m_a));
      chk("rf_wr_val",  int'(rf_wr_val),  int'(m_v));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq [4];
    int hs, wr;
    seq = '{1, 2, 1, 2};

    // Reset state
    cyc(); cyc();
    chk("rst_en", int'(rf_wr_en), 0);
    chk("rst_addr", int'(rf_wr_addr), 0);
    chk("rst_val", int'(rf_wr_val), 0);
    chk("rst_busy", int'(clr_busy), 0);
    chk("rst_done", int'(clr_done), 0);
    req0_valid = 1; req1_valid = 1; #1;
    chk("rst_rdy0", int'(req0_ready), 0);
    chk("rst_rdy1", int'(req1_ready), 0);
    req0_valid = 0; req1_valid = 0;
    rst = 0;
    cyc();

    // Single write
    req0_valid = 1; req0_addr = 5; req0_data = 4'hA; #1;
    chk("single_rdy0", int'(req0_ready), 1);
    cyc();
    req0_valid = 0;
    chk("single_en", int'(rf_wr_en), 1);
    chk("single_addr", int'(rf_wr_addr), 5);
    chk("single_val", int'(rf_wr_val), 10);
    cyc();
    chk("idle_en", int'(rf_wr_en), 0);
    chk("idle_hold_addr", int'(rf_wr_addr), 5);

    // Contention right after reset
    rst = 1; cyc(); rst = 0;
    req0_valid = 1; req0_addr = 1; req0_data = 1;
    req1_valid = 1; req1_addr = 2; req1_data = 2;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_addr", int'(rf_wr_addr), seq[i]);
      chk("rr_val", int'(rf_wr_val), seq[i]);
    end
    req0_valid = 0; req1_valid = 0;
    cyc();

    // Clear sweep
    clr_req = 1; cyc(); clr_req = 0;
    for (int i = 0; i < 8; i++) begin
      chk("sweep_en", int'(rf_wr_en), 1);
      chk("sweep_addr", int'(rf_wr_addr), i);
      chk("sweep_val", int'(rf_wr_val), 0);
      chk("sweep_busy", int'(clr_busy), 1);
      cyc();
    end
    chk("sweep_done", int'(clr_done), 1);
    chk("sweep_done_busy", int'(clr_busy), 0);
    chk("sweep_done_en", int'(rf_wr_en), 0);
    cyc();
    chk("sweep_done_pulse", int'(clr_done), 0);

    // Clear vs write
    clr_req = 1; req1_valid = 1; req1_addr = 6; req1_data = 3; #1;
    chk("cvw_rdy1", int'(req1_ready), 0);
    cyc(); clr_req = 0;
    repeat (8) cyc();
    chk("cvw_done", int'(clr_done), 1);
    chk("cvw_rdy1_done", int'(req1_ready), 1);
    cyc(); req1_valid = 0;
    chk("cvw_en", int'(rf_wr_en), 1);
    chk("cvw_addr", int'(rf_wr_addr), 6);
    chk("cvw_val", int'(rf_wr_val), 3);
    cyc();

    // Reset mid-sweep (during the fourth sweep cycle)
    clr_req = 1; cyc(); clr_req = 0;
    repeat (3) cyc();
    chk("mid_addr", int'(rf_wr_addr), 3);
    rst = 1; cyc(); rst = 0;
    chk("mid_en", int'(rf_wr_en), 0);
    chk("mid_busy", int'(clr_busy), 0);
    req0_valid = 1; req0_addr = 3; req0_data = 9;
    req1_valid = 1; req1_addr = 4; req1_data = 1; #1;
    chk("mid_rdy0", int'(req0_ready), 1);
    chk("mid_rdy1", int'(req1_ready), 0);
    cyc(); req0_valid = 0; req1_valid = 0;
    chk("mid_wr_addr", int'(rf_wr_addr), 3);
    chk("mid_wr_val", int'(rf_wr_val), 9);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("mid_no_done", int'(clr_done), 0);
    end

    // Backpressure: req1 held across the tail of a sweep
    hs = 0; wr = 0;
    clr_req = 1; cyc(); clr_req = 0;
    repeat (3) cyc();
    req1_valid = 1; req1_addr = 4; req1_data = 7;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (req1_valid && req1_ready) hs++;
      cyc();
      if (rf_wr_en && rf_wr_addr == 3'd4 && rf_wr_val == 4'd7) wr++;
    end
    req1_valid = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (rf_wr_en && rf_wr_addr == 3'd4 && rf_wr_val == 4'd7) wr++;
    end
    chk("bp_handshakes", hs, 1);
    chk("bp_writes", wr, 1);

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rf_wr_ctrl.md
RF_WR_CTRL -- requirements
Module: rf_wr_ctrl

Interface
REQ-001 SHALL have parameter CLR_VAL, default 4'b0000, the value written to every register during a clear sweep.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 each, write request present from requester 0 and requester 1.
REQ-005 SHALL have ports req0_ready and req1_ready, output, 1 each, request accepted this cycle.
REQ-006 SHALL have ports req0_addr and req1_addr, input, 3 each, target register index 0..7.
REQ-007 SHALL have ports req0_data and req1_data, input, 4 each, write data.
REQ-008 SHALL have port clr_req, input, 1, request to clear all eight registers.
REQ-009 SHALL have port clr_busy, output, 1, high while the clear sweep is active.
REQ-010 SHALL have port clr_done, output, 1, one-cycle pulse when the sweep completes.
REQ-011 SHALL have ports rf_wr_addr (output, 3), rf_wr_val (output, 4) and rf_wr_en (output, 1), which drive the 8x4 register file write port directly.

Function
REQ-012 SHALL implement FSM states IDLE and CLEAR, plus a 3-bit sweep counter cnt and a 1-bit round-robin pointer prio.
REQ-013 SHALL register rf_wr_addr, rf_wr_val, rf_wr_en, clr_busy and clr_done as flops; no combinational path from inputs to these outputs.
REQ-014 SHALL drive ready combinationally in IDLE with clr_req=0:
  - req0_ready = req0_valid & (!req1_valid | prio==0)
  - req1_ready = req1_valid & (!req0_valid | prio==1)
REQ-015 SHALL hold both readies at 0 in CLEAR, and in IDLE whenever clr_req=1 (clear has priority over writes).
REQ-016 SHALL, on a handshake (valid&ready) at edge t, present that requester's addr/data on rf_wr_addr/rf_wr_val with rf_wr_en=1 during cycle t+1 (one-cycle latency); at most one handshake per cycle.
REQ-017 SHALL set prio to the non-granted requester after each handshake; prio is unchanged on cycles with no handshake.
REQ-018 SHALL drive rf_wr_en=0 in any IDLE cycle not following a handshake; rf_wr_addr/rf_wr_val hold their last values.
REQ-019 SHALL, when clr_req=1 is sampled in IDLE at edge t, enter CLEAR with cnt=0.
REQ-020 SHALL, in cycles t+1..t+8, drive rf_wr_en=1, rf_wr_addr=cnt (0,1,...,7) and rf_wr_val=CLR_VAL, with clr_busy=1, incrementing cnt each cycle.
REQ-021 SHALL, after the cnt=7 write cycle, return to IDLE and assert clr_done=1 for exactly one cycle (t+9) with clr_busy=0; readies may assert in that cycle.
REQ-022 SHALL ignore clr_req while in CLEAR; a clr_req still high at t+9 starts a new sweep.
REQ-023 SHALL ignore requester addr/data while ready is low; valid may stay high indefinitely without loss.

Reset
REQ-024 SHALL, when rst=1 at an edge, set state=IDLE, cnt=0, prio=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_val=0, clr_busy=0 and clr_done=0.
REQ-025 SHALL, on reset during CLEAR, abort the sweep without a clr_done pulse; remaining registers are left unwritten.
REQ-026 SHALL hold both readies at 0 while rst=1.

Structure
REQ-027 SHALL place the shared constants in package rf_pkg: NUM_REGS=8, ADDR_W=3, DATA_W=4, and the state encoding (IDLE=0, CLEAR=1).
REQ-028 SHALL contain one sub-module, rr_arb2 (2-way round-robin grant from valids and prio); all other logic is inline.

Verification
REQ-029 Single write: req0 valid, addr=5, data=4'hA -> req0_ready=1 the same cycle; next cycle rf_wr_en=1, rf_wr_addr=5, rf_wr_val=4'hA.
REQ-030 Contention: both valid for 4 cycles after reset (req0 addr1/data1, req1 addr2/data2) -> grants alternate 0,1,0,1; rf_wr_addr sequence 1,2,1,2.
REQ-031 Clear sweep: clr_req pulsed 1 cycle in IDLE -> 8 cycles with rf_wr_en=1 and rf_wr_addr=0..7, rf_wr_val=0, clr_busy=1; then clr_done=1 for exactly 1 cycle.
REQ-032 Clear vs write: clr_req=1 and req1_valid=1 in the same cycle -> no ready; sweep runs; req1 is accepted in the clr_done cycle and written the cycle after.
REQ-033 Reset mid-sweep: rst=1 at sweep cycle 4 -> next cycle rf_wr_en=0, clr_busy=0; no clr_done; after release, req0 write addr=3 is accepted with prio=0.
REQ-034 Backpressure: req1 valid held for 6 cycles while a sweep is active -> exactly one handshake after the sweep, and exactly one rf write of req1's data.
